cv32e40p_obi_arbiter: RTL and testbench
=======================================

# cv32e40p_obi_arbiter

- Two-to-one OBI arbiter that lets the cv32e40p instruction and data ports share one single-ported memory.
- Sits between the core's instruction/data interfaces and the memory model or SRAM in the Verilator bench.
- Picks one requester per cycle and holds its request stable until the memory grants it.
- Tracks outstanding transactions in an in-order ID FIFO and routes each rvalid/rdata back to the port that issued it.

## Interface
Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (≥1); sets ID FIFO depth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  core instruction request
- instr_addr_i  in  32  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- data_req_i  in  1  core data request
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable (0 for instruction)
- mem_be_o  out  4  memory byte enables (4'hF for instruction)
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data (0 for instruction)
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid, in order
- mem_rdata_i  in  32  memory read data
- err_o  out  1  sticky error: rvalid received with no transaction outstanding

Clocking and reset (decided): one clock, clk_i; reset rst_ni, asynchronous, active-low.

## Operation
- State:
  - lock flag plus locked-port bit.
  - ID FIFO of MAX_OUTSTANDING one-bit entries (0 = data, 1 = instr), with read/write pointers and a count.
  - last-winner bit (used only in round-robin mode).
  - err flag.
- Selection:
  - If lock=1, the locked port is selected.
  - Else if only one port requests, that port is selected.
  - Else the arbitration policy decides (see Configuration).
- mem_req_o = (selected port's req) & ~fifo_full. Request/address/we/be/wdata are muxed from the selected port.
- Grant: only the selected port sees a grant; its gnt_o = mem_gnt_i & mem_req_o. The other port's gnt_o = 0.
- Lock:
  - Set when mem_req_o=1 and mem_gnt_i=0, which keeps selection and fields stable as OBI requires.
  - Cleared on the handshake (mem_req_o & mem_gnt_i).
- On handshake:
  - Push the selected port ID into the FIFO.
  - Update last-winner to the selected port.
- On mem_rvalid_i with FIFO non-empty:
  - Pop the FIFO.
  - Assert rvalid_o on the port given by the head ID.
- rdata: mem_rdata_i is broadcast to both rdata outputs; only the rvalid outputs are qualified.
- On mem_rvalid_i with FIFO empty:
  - Set err_o, drop the response, no rvalid_o.
  - err_o clears only on reset.
- Simultaneous push and pop in one cycle: count unchanged and both pointers advance.
- Full FIFO:
  - mem_req_o is forced to 0 even if a pop happens in the same cycle; the grant path does not depend on rvalid.
  - The lock flag is unaffected while full.
- Pointers wrap modulo MAX_OUTSTANDING; count ranges 0..MAX_OUTSTANDING.

## Timing
- Request path is combinational: core req → mem_req_o in the same cycle, and mem_gnt_i → core gnt in the same cycle.
- Response path is combinational: mem_rvalid_i → port rvalid_o in the same cycle. The FIFO head is a registered value.
- Arbiter adds zero cycles of latency.
- Back-to-back grants to alternating ports are allowed every cycle while the FIFO is not full.
- Reset values: lock=0, FIFO empty, last-winner=0 (data), err_o=0. All outputs follow combinationally from inputs, so with no requests every output is 0.
- Reset mid-operation: all outstanding IDs are discarded. Any later rvalid sets err_o.

## Configuration
- Macro: CV32E40P_OBI_ARB_RR_EN.
- Defined (round-robin): on a conflict with lock=0, the port that is not last-winner wins. After reset the first conflict goes to instr.
- Undefined (fixed priority): on a conflict, data always wins and the last-winner register is not implemented.
- The lock rule applies in both modes.

## Test plan
- Instruction-only traffic, memory gnt=1, rvalid one cycle later, addresses 0x0, 0x4, 0x8 → three instr_gnt_o pulses on consecutive cycles, instr_rvalid_o with rdata 0x00000013 each, data_rvalid_o never asserted.
- Both ports request together, data write to 0x1000 with be=4'b0011, mem gnt=1:
  - Fixed mode: data granted first, instr the next cycle.
  - RR mode: instr first, then data.
  - In both modes, mem_we_o=1 and mem_be_o=4'b0011 appear only in the data cycle.
- Instr request with mem_gnt_i held 0 for 3 cycles while data_req_i rises on cycle 1 → mem_addr_o stays the instr address, data_gnt_o=0 throughout; instr granted on cycle 3, data granted on cycle 4.
- MAX_OUTSTANDING=2, memory grants every cycle and withholds rvalid → exactly two grants, then mem_req_o=0. The first rvalid arrives in the same cycle as a pending request; mem_req_o re-asserts the following cycle.
- Interleaved data then instr grants, responses 0xAAAA_AAAA then 0x5555_5555 → data_rvalid_o on the first, instr_rvalid_o on the second.
- rvalid injected with nothing outstanding → err_o=1 and remains 1. Assert rst_ni with 2 transactions outstanding → after reset, FIFO empty and err_o=0.

Source files
------------

// File: rtl/cv32e40p_obi_arbiter.sv
// Two-to-one OBI arbiter: cv32e40p instruction and data ports share one memory port.
// Define CV32E40P_OBI_ARB_RR_EN for round-robin conflict resolution; default is fixed data priority.
//
// lock_q | meaning
// -------+--------------------------------------------------------------
//   0    | free: selection follows the requests and the arbitration policy
//   1    | locked: request issued but not granted; lock_port_q held stable

module cv32e40p_obi_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,

   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,

   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,

   output logic        err_o
);

   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);

   logic                       lock_q;
   logic                       lock_port_q;
   logic [MAX_OUTSTANDING-1:0] id_fifo_q;
   logic [PW-1:0]              rd_ptr_q;
   logic [PW-1:0]              wr_ptr_q;
   logic [CW-1:0]              count_q;
   logic                       err_q;

   logic sel_instr;
   logic sel_req;
   logic fifo_full;
   logic fifo_empty;
   logic handshake;
   logic push;
   logic pop;
   logic head_id;
   logic conflict_instr;

`ifdef CV32E40P_OBI_ARB_RR_EN
   logic last_winner_q;

   assign conflict_instr = ~last_winner_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_winner_q <= 1'b0;
      end else if (handshake) begin
         last_winner_q <= sel_instr;
      end
   end
`else
   assign conflict_instr = 1'b0;
`endif

   always_comb begin
      sel_instr = 1'b0;
      if (lock_q) begin
         sel_instr = lock_port_q;
      end else if (instr_req_i && !data_req_i) begin
         sel_instr = 1'b1;
      end else if (instr_req_i && data_req_i) begin
         sel_instr = conflict_instr;
      end
   end

   assign sel_req    = sel_instr ? instr_req_i : data_req_i;
   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);

   // A full FIFO blocks the request outright; a same-cycle pop does not reopen it.
   assign mem_req_o  = sel_req & ~fifo_full;
   assign handshake  = mem_req_o & mem_gnt_i;
   assign push       = handshake;
   assign pop        = mem_rvalid_i & ~fifo_empty;

   assign mem_we_o    = mem_req_o & ~sel_instr & data_we_i;
   assign mem_be_o    = ~mem_req_o ? 4'h0 : (sel_instr ? 4'hF : data_be_i);
   assign mem_addr_o  = ~mem_req_o ? 32'h0 : (sel_instr ? instr_addr_i : data_addr_i);
   assign mem_wdata_o = (mem_req_o && !sel_instr) ? data_wdata_i : 32'h0;

   assign instr_gnt_o = handshake & sel_instr;
   assign data_gnt_o  = handshake & ~sel_instr;

   assign head_id        = id_fifo_q[rd_ptr_q];
   assign instr_rvalid_o = pop & head_id;
   assign data_rvalid_o  = pop & ~head_id;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign err_o          = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q      <= 1'b0;
         lock_port_q <= 1'b0;
      end else if (handshake) begin
         lock_q <= 1'b0;
      end else if (mem_req_o) begin
         lock_q      <= 1'b1;
         lock_port_q <= sel_instr;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_fifo_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         if (push) begin
            id_fifo_q[wr_ptr_q] <= sel_instr;
            wr_ptr_q            <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (mem_rvalid_i && fifo_empty) begin
         err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
// Directed bench for cv32e40p_obi_arbiter; expectations follow CV32E40P_OBI_ARB_RR_EN when defined.

module tb_cv32e40p_obi_arbiter;

`ifdef CV32E40P_OBI_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   cv32e40p_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .err_o          (err_o)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      instr_req_i  = 1'b0;
      instr_addr_i = 32'h0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'h0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
   endtask

   task automatic do_reset();
      idle();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      settle();
   endtask

   initial begin
      // reset state
      idle();
      rst_ni = 1'b0;
      settle();
      chk_val("rst_mem_req",      mem_req_o,      0);
      chk_val("rst_mem_addr",     mem_addr_o,     0);
      chk_val("rst_mem_be",       mem_be_o,       0);
      chk_val("rst_instr_gnt",    instr_gnt_o,    0);
      chk_val("rst_data_gnt",     data_gnt_o,     0);
      chk_val("rst_instr_rvalid", instr_rvalid_o, 0);
      chk_val("rst_data_rvalid",  data_rvalid_o,  0);
      chk_val("rst_err",          err_o,          0);
      tick();
      rst_ni = 1'b1;
      tick();

      // instruction-only stream, rvalid one cycle after each grant
      for (int i = 0; i < 4; i++) begin
         idle();
         instr_req_i  = (i < 3);
         instr_addr_i = 32'(4 * i);
         mem_gnt_i    = 1'b1;
         mem_rvalid_i = (i > 0);
         mem_rdata_i  = (i > 0) ? 32'h0000_0013 : 32'h0;
         settle();
         chk_val($sformatf("ifetch%0d_gnt", i),    instr_gnt_o,    (i < 3));
         chk_val($sformatf("ifetch%0d_addr", i),   mem_addr_o,     (i < 3) ? 32'(4 * i) : 32'h0);
         chk_val($sformatf("ifetch%0d_rvalid", i), instr_rvalid_o, (i > 0));
         chk_val($sformatf("ifetch%0d_drvalid", i), data_rvalid_o, 0);
         chk_val($sformatf("ifetch%0d_dgnt", i),   data_gnt_o,     0);
         if (i > 0) chk_val($sformatf("ifetch%0d_rdata", i), instr_rdata_o, 32'h0000_0013);
         tick();
      end
      idle();
      settle();
      chk_val("ifetch_idle_req", mem_req_o, 0);

      // conflict straight after reset
      do_reset();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0020;
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_be_i    = 4'b0011;
      data_addr_i  = 32'h0000_1000;
      data_wdata_i = 32'hDEAD_BEEF;
      mem_gnt_i    = 1'b1;
      settle();
      chk_val("cf1_data_gnt",  data_gnt_o,  !RR);
      chk_val("cf1_instr_gnt", instr_gnt_o, RR);
      chk_val("cf1_we",        mem_we_o,    !RR);
      chk_val("cf1_be",        mem_be_o,    RR ? 4'hF : 4'b0011);
      chk_val("cf1_addr",      mem_addr_o,  RR ? 32'h0000_0020 : 32'h0000_1000);
      chk_val("cf1_wdata",     mem_wdata_o, RR ? 32'h0 : 32'hDEAD_BEEF);
      tick();
      data_req_i  = RR;
      instr_req_i = !RR;
      settle();
      chk_val("cf2_data_gnt",  data_gnt_o,  RR);
      chk_val("cf2_instr_gnt", instr_gnt_o, !RR);
      chk_val("cf2_we",        mem_we_o,    RR);
      chk_val("cf2_be",        mem_be_o,    RR ? 4'b0011 : 4'hF);
      chk_val("cf2_addr",      mem_addr_o,  RR ? 32'h0000_1000 : 32'h0000_0020);
      tick();
      idle();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hAAAA_AAAA;
      settle();
      chk_val("rsp1_data_rvalid",  data_rvalid_o,  !RR);
      chk_val("rsp1_instr_rvalid", instr_rvalid_o, RR);
      chk_val("rsp1_data_rdata",   data_rdata_o,   32'hAAAA_AAAA);
      tick();
      mem_rdata_i = 32'h5555_5555;
      settle();
      chk_val("rsp2_data_rvalid",  data_rvalid_o,  RR);
      chk_val("rsp2_instr_rvalid", instr_rvalid_o, !RR);
      chk_val("rsp2_instr_rdata",  instr_rdata_o,  32'h5555_5555);
      tick();

      // lock: instr held while memory stalls, data rises on cycle 1
      idle();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0040;
      data_addr_i  = 32'h0000_2000;
      data_be_i    = 4'hF;
      for (int c = 0; c < 5; c++) begin
         data_req_i = (c >= 1);
         instr_req_i = (c <= 3);
         mem_gnt_i  = (c >= 3);
         settle();
         chk_val($sformatf("lock%0d_req", c),       mem_req_o,   1);
         chk_val($sformatf("lock%0d_addr", c),      mem_addr_o,  (c <= 3) ? 32'h0000_0040 : 32'h0000_2000);
         chk_val($sformatf("lock%0d_instr_gnt", c), instr_gnt_o, (c == 3));
         chk_val($sformatf("lock%0d_data_gnt", c),  data_gnt_o,  (c == 4));
         tick();
      end
      idle();
      mem_rvalid_i = 1'b1;
      settle();
      chk_val("lockrsp1_instr_rvalid", instr_rvalid_o, 1);
      tick();
      settle();
      chk_val("lockrsp2_data_rvalid", data_rvalid_o, 1);
      tick();

      // full FIFO: two grants, stall, pop with request pending, resume next cycle
      idle();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0100;
      mem_gnt_i    = 1'b1;
      for (int c = 0; c < 5; c++) begin
         mem_rvalid_i = (c == 3);
         settle();
         chk_val($sformatf("full%0d_req", c),    mem_req_o,      (c != 2 && c != 3));
         chk_val($sformatf("full%0d_gnt", c),    instr_gnt_o,    (c != 2 && c != 3));
         chk_val($sformatf("full%0d_rvalid", c), instr_rvalid_o, (c == 3));
         tick();
      end

      // drain, then an unsolicited response
      idle();
      mem_rvalid_i = 1'b1;
      settle();
      chk_val("drain1_rvalid", instr_rvalid_o, 1);
      tick();
      settle();
      chk_val("drain2_rvalid", instr_rvalid_o, 1);
      chk_val("drain2_err",    err_o,          0);
      tick();
      settle();
      chk_val("orphan_instr_rvalid", instr_rvalid_o, 0);
      chk_val("orphan_data_rvalid",  data_rvalid_o,  0);
      tick();
      idle();
      settle();
      chk_val("orphan_err_set", err_o, 1);

      // err stays set through further traffic; leave two outstanding
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      tick();
      tick();
      idle();
      settle();
      chk_val("err_sticky", err_o, 1);

      // reset with two outstanding discards them
      rst_ni = 1'b0;
      settle();
      chk_val("rst_mid_err", err_o, 0);
      tick();
      rst_ni = 1'b1;
      settle();
      mem_rvalid_i = 1'b1;
      settle();
      chk_val("post_rst_instr_rvalid", instr_rvalid_o, 0);
      chk_val("post_rst_data_rvalid",  data_rvalid_o,  0);
      tick();
      idle();
      settle();
      chk_val("post_rst_err", err_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
